// File: rtl/strobe_transmitter_if.sv
// Request/strobe bundle between the capture-domain logic
// and the strobe transmitter.
interface strobe_transmitter_if;
  logic strobe_i;
  logic ack_async_i;
  logic strobe_o;
  logic busy_o;
  logic done_o;
  logic drop_o;
  logic timeout_o;

  modport master (
    output strobe_i,
    output ack_async_i,
    input  strobe_o,
    input  busy_o,
    input  done_o,
    input  drop_o,
    input  timeout_o
  );

  modport slave (
    input  strobe_i,
    input  ack_async_i,
    output strobe_o,
    output busy_o,
    output done_o,
    output drop_o,
    output timeout_o
  );
endinterface

// File: rtl/strobe_transmitter.sv
// Turns 1-cycle request pulses into wide level strobes for a
// far-domain edge detector, with optional 4-phase ack handshake.
module strobe_transmitter #(
  parameter int HIGH_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int USE_ACK        = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  strobe_transmitter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HI_N  = CW'(HIGH_CYCLES);
  localparam logic [CW-1:0] GAP_N = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] TO_N  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    WAIT_ACK_LOW,
    GAP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          pend;
  logic          pend_nxt;
  logic          ack_m;
  logic          ack_s;
  logic          fin;
  logic          take;
  logic          consume;
  logic          set_p;
  logic          done_nxt;
  logic          to_nxt;
  logic          drop_nxt;

  // Two-flop synchronizer: the only place the async ack is used
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= bus.ack_async_i;
      ack_s <= ack_m;
    end
  end

  // Next state, phase counter and pending-slot bookkeeping
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    fin       = 1'b0;
    take      = 1'b0;
    done_nxt  = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      IDLE: take = bus.strobe_i | pend;
      HIGH: begin
        if (cnt >= HI_N && (USE_ACK == 0 || ack_s)) begin
          if (USE_ACK != 0) begin
            state_nxt = WAIT_ACK_LOW;
            cnt_nxt   = ONE;
          end else begin
            done_nxt = 1'b1;
            fin      = 1'b1;
          end
        end else if (cnt >= TO_N) begin
          to_nxt = 1'b1;
          fin    = 1'b1;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_s) begin
          done_nxt = 1'b1;
          fin      = 1'b1;
        end else if (cnt >= TO_N) begin
          to_nxt = 1'b1;
          fin    = 1'b1;
        end
      end
      GAP: begin
        if (cnt >= GAP_N) begin
          if (pend) take = 1'b1;
          else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A finished transfer either rests in GAP or, with no gap,
    // goes straight to the next request or back to IDLE
    if (fin) begin
      if (GAP_CYCLES > 0) begin
        state_nxt = GAP;
        cnt_nxt   = ONE;
      end else if (pend) begin
        take = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end
    if (take) begin
      state_nxt = HIGH;
      cnt_nxt   = ONE;
    end
    consume  = take & pend;
    set_p    = bus.strobe_i & (pend ? consume : (state != IDLE));
    drop_nxt = bus.strobe_i & pend & ~consume;
    pend_nxt = set_p | (pend & ~consume);
  end

  // Core state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.strobe_o  <= 1'b0;
      bus.busy_o    <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.drop_o    <= 1'b0;
      bus.timeout_o <= 1'b0;
    end else begin
      bus.strobe_o  <= (state_nxt == HIGH);
      bus.busy_o    <= (state_nxt != IDLE) | pend_nxt;
      bus.done_o    <= done_nxt;
      bus.drop_o    <= drop_nxt;
      bus.timeout_o <= to_nxt;
    end
  end

endmodule

// File: tb/tb_strobe_transmitter.sv
// Self-checking bench: directed timelines plus random traffic
// against a phase/age reference model, three configurations.
module tb_strobe_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  strobe_transmitter_if if0 ();
  strobe_transmitter_if if1 ();
  strobe_transmitter_if if2 ();

  strobe_transmitter #(
    .HIGH_CYCLES(4), .GAP_CYCLES(2),
    .USE_ACK(0), .TIMEOUT_CYCLES(256)
  ) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));

  strobe_transmitter #(
    .HIGH_CYCLES(4), .GAP_CYCLES(2),
    .USE_ACK(1), .TIMEOUT_CYCLES(16)
  ) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  strobe_transmitter #(
    .HIGH_CYCLES(1), .GAP_CYCLES(0),
    .USE_ACK(1), .TIMEOUT_CYCLES(8)
  ) dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));

  // phase: 0 idle, 1 strobe high, 2 wait ack low, 3 gap
  // age: cycles spent in the current phase (1 = first)
  // pq: number of queued requests (slot depth 1)
  typedef struct {
    int ph;
    int age;
    int pq;
    bit s1;
    bit s2;
    bit e_str;
    bit e_busy;
    bit e_done;
    bit e_drop;
    bit e_to;
  } m_t;

  m_t m0 = '{default: 0};
  m_t m1 = '{default: 0};
  m_t m2 = '{default: 0};

  function automatic m_t mstep(m_t m, bit r, bit req, bit ack,
                               int H, int G, int UA, int TO);
    m_t n;
    bit as;
    bit fin;
    bit go;
    bit use_p;
    n = m;
    n.e_done = 0;
    n.e_drop = 0;
    n.e_to = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    as = m.s2;
    n.s2 = m.s1;
    n.s1 = ack;
    fin = 0;
    go = 0;
    n.age = m.age + 1;
    case (m.ph)
      0: go = req || (m.pq > 0);
      1: begin
        if (m.age >= H && (UA == 0 || as)) begin
          if (UA != 0) begin
            n.ph = 2;
            n.age = 1;
          end else begin
            n.e_done = 1;
            fin = 1;
          end
        end else if (m.age >= TO) begin
          n.e_to = 1;
          fin = 1;
        end
      end
      2: begin
        if (!as) begin
          n.e_done = 1;
          fin = 1;
        end else if (m.age >= TO) begin
          n.e_to = 1;
          fin = 1;
        end
      end
      default: begin
        if (m.age >= G) begin
          if (m.pq > 0) go = 1;
          else n.ph = 0;
        end
      end
    endcase
    if (fin) begin
      if (G > 0) begin
        n.ph = 3;
        n.age = 1;
      end else if (m.pq > 0) go = 1;
      else n.ph = 0;
    end
    use_p = go && (m.pq > 0);
    if (go) begin
      n.ph = 1;
      n.age = 1;
    end
    n.pq = m.pq - (use_p ? 1 : 0);
    if (req && !(m.ph == 0 && m.pq == 0)) begin
      if (n.pq == 0) n.pq = 1;
      else n.e_drop = 1;
    end
    n.e_str = (n.ph == 1);
    n.e_busy = (n.ph != 0) || (n.pq > 0);
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= mstep(m0, rst, if0.strobe_i, if0.ack_async_i, 4, 2, 0, 256);
    m1 <= mstep(m1, rst, if1.strobe_i, if1.ack_async_i, 4, 2, 1, 16);
    m2 <= mstep(m2, rst, if2.strobe_i, if2.ack_async_i, 1, 0, 1, 8);
  end

  function automatic logic [4:0] pk(m_t m);
    return {m.e_str, m.e_busy, m.e_done, m.e_drop, m.e_to};
  endfunction

  task automatic cmp(string nm, logic [4:0] got, logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b (str busy done drop to)",
               nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model0", {if0.strobe_o, if0.busy_o, if0.done_o,
                     if0.drop_o, if0.timeout_o}, pk(m0));
      cmp("model1", {if1.strobe_o, if1.busy_o, if1.done_o,
                     if1.drop_o, if1.timeout_o}, pk(m1));
      cmp("model2", {if2.strobe_o, if2.busy_o, if2.done_o,
                     if2.drop_o, if2.timeout_o}, pk(m2));
    end
  end

  // trace bits: 4 strobe, 3 busy, 2 done, 1 drop, 0 timeout
  logic [4:0] tr0 [0:63];
  logic [4:0] tr1 [0:63];
  bit st0 [0:63];
  bit st1 [0:63];
  bit ak1 [0:63];
  bit rs  [0:63];

  task automatic lit(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    if0.strobe_i = 0; if0.ack_async_i = 0;
    if1.strobe_i = 0; if1.ack_async_i = 0;
    if2.strobe_i = 0; if2.ack_async_i = 0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      st0[i] = 0; st1[i] = 0; ak1[i] = 0; rs[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic play(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tr0[c] = {if0.strobe_o, if0.busy_o, if0.done_o,
                if0.drop_o, if0.timeout_o};
      tr1[c] = {if1.strobe_o, if1.busy_o, if1.done_o,
                if1.drop_o, if1.timeout_o};
      rst = rs[c];
      if0.strobe_i = st0[c];
      if1.strobe_i = st1[c];
      if1.ack_async_i = ak1[c];
    end
  endtask

  initial begin
    int ndone;
    int nedge;
    idle_inputs();
    do_reset();
    chk_en = 1;
    @(negedge clk);
    lit("reset_out0", int'({if0.strobe_o, if0.busy_o, if0.done_o,
                           if0.drop_o, if0.timeout_o}), 0);
    lit("reset_out1", int'({if1.strobe_o, if1.busy_o, if1.done_o,
                           if1.drop_o, if1.timeout_o}), 0);

    // single pulse (dut0) and ack handshake (dut1)
    do_reset();
    clear_stim();
    st0[10] = 1;
    st1[10] = 1;
    for (int i = 14; i < 22; i++) ak1[i] = 1;
    play(40);
    lit("t1_str10", tr0[10][4], 0);
    lit("t1_str11", tr0[11][4], 1);
    lit("t1_str14", tr0[14][4], 1);
    lit("t1_str15", tr0[15][4], 0);
    lit("t1_done14", tr0[14][2], 0);
    lit("t1_done15", tr0[15][2], 1);
    lit("t1_busy16", tr0[16][3], 1);
    lit("t1_busy17", tr0[17][3], 0);
    lit("t4_str16", tr1[16][4], 1);
    lit("t4_str17", tr1[17][4], 0);
    lit("t4_done24", tr1[24][2], 0);
    lit("t4_done25", tr1[25][2], 1);
    lit("t4_busy26", tr1[26][3], 1);
    lit("t4_busy27", tr1[27][3], 0);

    // back-to-back with drop (dut0), timeout with pending (dut1)
    do_reset();
    clear_stim();
    st0[10] = 1; st0[12] = 1; st0[13] = 1;
    st1[10] = 1; st1[12] = 1;
    play(60);
    lit("t3_drop13", tr0[13][1], 0);
    lit("t3_drop14", tr0[14][1], 1);
    lit("t3_str16", tr0[16][4], 0);
    lit("t3_str17", tr0[17][4], 1);
    lit("t3_str20", tr0[20][4], 1);
    lit("t3_str21", tr0[21][4], 0);
    lit("t3_done21", tr0[21][2], 1);
    lit("t3_busy23", tr0[23][3], 0);
    nedge = 0;
    for (int i = 1; i < 60; i++)
      if (tr0[i][4] && !tr0[i-1][4]) nedge++;
    lit("t3_strobes", nedge, 2);
    lit("t5_str26", tr1[26][4], 1);
    lit("t5_str27", tr1[27][4], 0);
    lit("t5_to27", tr1[27][0], 1);
    lit("t5_str28", tr1[28][4], 0);
    lit("t5_str29", tr1[29][4], 1);
    lit("t5_to45", tr1[45][0], 1);
    ndone = 0;
    for (int i = 0; i < 60; i++) ndone += int'(tr1[i][2]);
    lit("t5_nodone", ndone, 0);

    // reset while high with a pending request (dut0)
    do_reset();
    clear_stim();
    st0[10] = 1; st0[12] = 1;
    rs[13] = 1;
    st0[20] = 1;
    play(40);
    lit("t6_str13", tr0[13][4], 1);
    lit("t6_str14", tr0[14][4], 0);
    lit("t6_busy14", tr0[14][3], 0);
    lit("t6_str17", tr0[17][4], 0);
    lit("t6_str21", tr0[21][4], 1);
    lit("t6_done25", tr0[25][2], 1);

    // random traffic, model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      if0.strobe_i = ($urandom_range(0, 5) == 0);
      if1.strobe_i = ($urandom_range(0, 9) == 0);
      if2.strobe_i = ($urandom_range(0, 2) == 0);
      if0.ack_async_i = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0)
        if1.ack_async_i = ~if1.ack_async_i;
      if ($urandom_range(0, 2) == 0)
        if2.ack_async_i = ~if2.ack_async_i;
    end
    @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
